crc_tx_framer: RTL



---
 rtl/crc_tx_pkg.sv | 31 +++
 rtl/crc_tx_lfsr.sv | 48 ++++
 rtl/crc_tx_framer.sv | 117 +++++++++++
 3 files changed

// File: rtl/crc_tx_pkg.sv
// ============================================================================
//  Module   : crc_tx_pkg
//  Brief    : Shared state encoding, polynomial constants and width helper
//             for the serial CRC transmit framer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package crc_tx_pkg;

   localparam logic [0:0] ST_DATA = 1'b0;
   localparam logic [0:0] ST_CRC  = 1'b1;

   localparam int          CRC_W_DEFAULT = 16;
   localparam logic [15:0] CRC16_CCITT   = 16'h1021;
   localparam logic [7:0]  CRC8          = 8'h07;
   localparam logic [31:0] CRC32         = 32'h04C11DB7;

   // Bits needed to hold a down-counter starting at value-1; never below 1.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/crc_tx_lfsr.sv
// ============================================================================
//  Module   : crc_tx_lfsr
//  Brief    : CRC remainder register: clear to init, direct-form update with
//             a payload bit, or left shift with zero fill to unload the CRC.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module crc_tx_lfsr #(
   parameter int               CRC_W    = 16,
   parameter logic [CRC_W-1:0] CRC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             update,
   input  logic             shift,
   input  logic             din,
   input  logic [CRC_W-1:0] poly,
   output logic             msb
);

   logic [CRC_W-1:0] crc;
   logic [CRC_W-1:0] step;
   logic             fb;

   always_comb begin
      fb      = din ^ crc[CRC_W-1];
      step    = {crc[CRC_W-2:0], 1'b0} ^ (poly & {CRC_W{fb}});
      step[0] = fb;
   end

   // Clear wins so the register is ready for a frame accepted right after.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         crc <= CRC_INIT;
      end else if (update) begin
         crc <= step;
      end else if (shift) begin
         crc <= {crc[CRC_W-2:0], 1'b0};
      end
   end

   assign msb = crc[CRC_W-1];

endmodule

`default_nettype wire

// File: rtl/crc_tx_framer.sv
// ============================================================================
//  Module   : crc_tx_framer
//  Brief    : Bit-serial CRC transmitter; echoes payload, then appends the
//             W-bit remainder MSB-first. Macro CRC_TX_CTRL_POLY_EN adds a
//             run-time polynomial input ctrl_poly.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module crc_tx_framer
   import crc_tx_pkg::*;
#(
   parameter int               CRC_W    = CRC_W_DEFAULT,
   parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC16_CCITT),
   parameter logic [CRC_W-1:0] CRC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_data,
   output logic             out_last,
   output logic             out_is_crc,
`ifdef CRC_TX_CTRL_POLY_EN
   input  logic [CRC_W-1:0] ctrl_poly,
`endif
   output logic             busy
);

   localparam int CNT_W = clog2(CRC_W);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CRC_W-1:0] poly;
   logic             slot_free;
   logic             accept;
   logic             crc_msb;
   logic             crc_clear;
   logic             crc_update;
   logic             crc_shift;

`ifdef CRC_TX_CTRL_POLY_EN
   assign poly = ctrl_poly;
`else
   assign poly = CRC_POLY;
`endif

   assign slot_free  = !out_valid || out_ready;
   assign in_ready   = (state == ST_DATA) && slot_free;
   assign accept     = in_valid && in_ready;
   assign crc_update = accept;
   assign crc_clear  = (state == ST_CRC) && slot_free && (cnt == '0);
   assign crc_shift  = (state == ST_CRC) && slot_free && (cnt != '0);

   crc_tx_lfsr #(
      .CRC_W    (CRC_W),
      .CRC_INIT (CRC_INIT)
   ) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (crc_clear),
      .update (crc_update),
      .shift  (crc_shift),
      .din    (in_data),
      .poly   (poly),
      .msb    (crc_msb)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_DATA;
         cnt        <= '0;
         out_valid  <= 1'b0;
         out_data   <= 1'b0;
         out_last   <= 1'b0;
         out_is_crc <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // A new frame accepted in the same cycle re-asserts busy below.
         if (out_valid && out_ready && out_last) busy <= 1'b0;
         case (state)
            ST_DATA: begin
               if (accept) begin
                  out_data   <= in_data;
                  out_is_crc <= 1'b0;
                  out_last   <= 1'b0;
                  out_valid  <= 1'b1;
                  busy       <= 1'b1;
                  if (in_last) begin
                     state <= ST_CRC;
                     cnt   <= CNT_W'(CRC_W - 1);
                  end
               end else if (slot_free) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               if (slot_free) begin
                  out_data   <= crc_msb;
                  out_is_crc <= 1'b1;
                  out_valid  <= 1'b1;
                  out_last   <= (cnt == '0);
                  cnt        <= cnt - 1'b1;
                  if (cnt == '0) state <= ST_DATA;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire
